// File: rtl/ndp_egress_queue.sv
// NDP egress queue: trims or drops packets by FIFO occupancy,
// then drains toward the egress port at a paced rate.
module ndp_egress_queue #(
  parameter int DATA_WIDTH     = 480,
  parameter int CTRL_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 6,
  parameter int TRIM_THRESH    = 48,
  parameter int DRAIN_INTERVAL = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_wr,
  input  logic [CTRL_WIDTH-1:0] in_ctl,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  output logic [CTRL_WIDTH-1:0] out_ctl,
  output logic [DATA_WIDTH-1:0] out_data,
  input  logic                  out_rdy,
  output logic [ADDR_WIDTH:0]   occupancy,
  output logic [ADDR_WIDTH:0]   peak_occ,
  output logic [31:0]           trim_cnt,
  output logic [31:0]           drop_cnt,
  output logic [31:0]           ovf_cnt,
  input  logic                  stat_clr
);

  typedef enum logic [1:0] {IDLE, PASS, TRIM, DROP} state_t;

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int WW    = CTRL_WIDTH + DATA_WIDTH;
  localparam logic [ADDR_WIDTH:0] FULL_OCC =
    (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] TRIM_OCC =
    (ADDR_WIDTH+1)'(TRIM_THRESH);
  localparam logic [31:0] PACE_LD = 32'(DRAIN_INTERVAL - 1);

  state_t                  state, nxt;
  logic [WW-1:0]           mem [DEPTH];
  logic [ADDR_WIDTH-1:0]   wr_ptr, rd_ptr;
  logic [31:0]             pace;
  logic                    push, pop;
  logic                    trim_inc, drop_inc, ovf_inc;
  logic [CTRL_WIDTH-1:0]   push_ctl;
  logic                    sop, eop, full, thresh;

  assign sop    = in_ctl[CTRL_WIDTH-1];
  assign eop    = in_ctl[CTRL_WIDTH-2];
  assign full   = (occupancy == FULL_OCC);
  assign thresh = (occupancy >= TRIM_OCC);
  assign pop    = (occupancy != '0) && (pace == '0) &&
                  (!out_valid || out_rdy);

  // A SOP always restarts packet classification, whatever the state.
  always_comb begin
    nxt      = state;
    push     = 1'b0;
    push_ctl = in_ctl;
    trim_inc = 1'b0;
    drop_inc = 1'b0;
    ovf_inc  = 1'b0;
    if (in_wr) begin
      if (sop) begin
        if (full) begin
          drop_inc = 1'b1;
          nxt      = eop ? IDLE : DROP;
        end else if (thresh) begin
          push                 = 1'b1;
          trim_inc             = 1'b1;
          push_ctl[CTRL_WIDTH-2] = 1'b1;
          push_ctl[CTRL_WIDTH-3] = 1'b1;
          nxt                  = eop ? IDLE : TRIM;
        end else begin
          push = 1'b1;
          nxt  = eop ? IDLE : PASS;
        end
      end else if (state != IDLE) begin
        if (state == PASS) begin
          if (full) ovf_inc = 1'b1;
          else      push    = 1'b1;
        end
        if (eop) nxt = IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push && !rst) mem[wr_ptr] <= {push_ctl, in_data};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
      pace      <= '0;
      out_valid <= 1'b0;
      out_ctl   <= '0;
      out_data  <= '0;
    end else begin
      state <= nxt;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   occupancy <= occupancy + 1'b1;
        2'b01:   occupancy <= occupancy - 1'b1;
        default: occupancy <= occupancy;
      endcase
      if (pop) begin
        out_valid           <= 1'b1;
        {out_ctl, out_data} <= mem[rd_ptr];
        pace                <= PACE_LD;
      end else begin
        if (out_rdy) out_valid <= 1'b0;
        if (pace != '0) pace <= pace - 32'd1;
      end
    end
  end

  // Clearing wins over a same-cycle increment.
  always_ff @(posedge clk) begin
    if (rst || stat_clr) begin
      peak_occ <= '0;
      trim_cnt <= '0;
      drop_cnt <= '0;
      ovf_cnt  <= '0;
    end else begin
      if (occupancy > peak_occ) peak_occ <= occupancy;
      if (trim_inc) trim_cnt <= trim_cnt + 32'd1;
      if (drop_inc) drop_cnt <= drop_cnt + 32'd1;
      if (ovf_inc)  ovf_cnt  <= ovf_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_ndp_egress_queue.sv
// Scoreboard bench for ndp_egress_queue: directed packets,
// trim/drop/overflow boundaries, backpressure, reset, pacing.
module tb_ndp_egress_queue;

  localparam int DW = 480;
  localparam int CW = 32;
  localparam int AW = 6;
  localparam logic [CW-1:0] SOP = 32'h8000_0000;
  localparam logic [CW-1:0] EOP = 32'h4000_0000;
  localparam logic [CW-1:0] TRM = 32'h2000_0000;

  typedef struct packed {
    logic [CW-1:0] c;
    logic [DW-1:0] d;
  } word_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, in_wr, out_rdy, stat_clr;
  logic [CW-1:0] in_ctl, out_ctl;
  logic [DW-1:0] in_data, out_data;
  logic          out_valid;
  logic [AW:0]   occupancy, peak_occ;
  logic [31:0]   trim_cnt, drop_cnt, ovf_cnt;

  logic          in_wr4, out_rdy4, out_valid4;
  logic [CW-1:0] in_ctl4, out_ctl4;
  logic [DW-1:0] in_data4, out_data4;
  logic [AW:0]   occ4, peak4;
  logic [31:0]   trim4, drop4, ovf4;

  ndp_egress_queue dut (
    .clk(clk), .rst(rst), .in_wr(in_wr), .in_ctl(in_ctl),
    .in_data(in_data), .out_valid(out_valid),
    .out_ctl(out_ctl), .out_data(out_data), .out_rdy(out_rdy),
    .occupancy(occupancy), .peak_occ(peak_occ),
    .trim_cnt(trim_cnt), .drop_cnt(drop_cnt),
    .ovf_cnt(ovf_cnt), .stat_clr(stat_clr)
  );

  ndp_egress_queue #(.DRAIN_INTERVAL(4)) dut4 (
    .clk(clk), .rst(rst), .in_wr(in_wr4), .in_ctl(in_ctl4),
    .in_data(in_data4), .out_valid(out_valid4),
    .out_ctl(out_ctl4), .out_data(out_data4),
    .out_rdy(out_rdy4), .occupancy(occ4), .peak_occ(peak4),
    .trim_cnt(trim4), .drop_cnt(drop4), .ovf_cnt(ovf4),
    .stat_clr(1'b0)
  );

  int    cyc = 0;
  int    tests = 0;
  int    fails = 0;
  word_t sb[$];
  word_t sb4[$];
  int    first_valid = -1;
  int    last_hs = -1;
  logic  prev_v = 1'b0;
  int    n4 = 0;
  int    last4 = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string nm, logic [63:0] act,
                     logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, required %0d", nm, act, exp);
    end
  endtask

  task automatic drive(logic w, logic [CW-1:0] c,
                       logic [DW-1:0] d);
    in_wr   = w;
    in_ctl  = c;
    in_data = d;
    @(posedge clk);
    #1;
  endtask

  task automatic send(logic [CW-1:0] c, logic [DW-1:0] d,
                      logic [CW-1:0] exp_c, logic keep);
    if (keep) sb.push_back({exp_c, d});
    drive(1'b1, c, d);
  endtask

  task automatic idle(int n);
    repeat (n) drive(1'b0, '0, '0);
  endtask

  task automatic wait_drain(int budget);
    int k = 0;
    while (sb.size() != 0 && k < budget) begin
      drive(1'b0, '0, '0);
      k++;
    end
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL drain_timeout: got %0d words left, required 0",
               sb.size());
    end
    idle(2);
  endtask

  // Main monitor: checks the head every valid cycle, pops on accept.
  always @(negedge clk) begin
    if (out_valid) begin
      if (!prev_v && first_valid < 0) first_valid = cyc;
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL out_unexpected: got ctl=%h data=%h, required none",
                 out_ctl, out_data[63:0]);
      end else begin
        if ({out_ctl, out_data} !== sb[0]) begin
          fails++;
          $display("FAIL out_word: got ctl=%h data=%h, required ctl=%h data=%h",
                   out_ctl, out_data[63:0], sb[0].c, sb[0].d[63:0]);
        end
        if (out_rdy) begin
          void'(sb.pop_front());
          last_hs = cyc;
        end
      end
    end
    prev_v = out_valid;
  end

  always @(negedge clk) begin
    if (out_valid4 && out_rdy4) begin
      tests++;
      if (sb4.size() == 0) begin
        fails++;
        $display("FAIL pace_unexpected: got data=%h, required none",
                 out_data4[63:0]);
      end else begin
        if ({out_ctl4, out_data4} !== sb4[0]) begin
          fails++;
          $display("FAIL pace_word: got data=%h, required data=%h",
                   out_data4[63:0], sb4[0].d[63:0]);
        end
        void'(sb4.pop_front());
      end
      if (n4 > 0) begin
        tests++;
        if (cyc - last4 != 4) begin
          fails++;
          $display("FAIL pace_gap: got %0d, required 4", cyc - last4);
        end
      end
      last4 = cyc;
      n4++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    logic [CW-1:0] c;
    rst = 1'b1; in_wr = 1'b0; in_ctl = '0; in_data = '0;
    out_rdy = 1'b0; stat_clr = 1'b0;
    in_wr4 = 1'b0; in_ctl4 = '0; in_data4 = '0; out_rdy4 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    chk("rst_out_valid", 64'(out_valid), 0);
    chk("rst_out_ctl", 64'(out_ctl), 0);
    chk("rst_out_data", {63'b0, |out_data}, 0);
    chk("rst_occupancy", 64'(occupancy), 0);
    chk("rst_peak", 64'(peak_occ), 0);
    chk("rst_counters", 64'(trim_cnt | drop_cnt | ovf_cnt), 0);

    // three-word packet, free-running downstream
    out_rdy = 1'b1;
    first_valid = -1;
    t0 = cyc;
    send(SOP, DW'(32'hA1), SOP, 1'b1);
    send('0, DW'(32'hA2), '0, 1'b1);
    send(EOP, DW'(32'hA3), EOP, 1'b1);
    wait_drain(50);
    chk("first_latency", 64'(first_valid - t0), 2);
    chk("last_word_cycle", 64'(last_hs - t0), 4);
    chk("pkt3_occupancy", 64'(occupancy), 0);

    // backpressure hold for 10 cycles
    out_rdy = 1'b0;
    send(SOP | 32'h11, DW'(32'hD1), SOP | 32'h11, 1'b1);
    send(EOP, DW'(32'hD2), EOP, 1'b1);
    idle(10);
    chk("hold_occupancy", 64'(occupancy), 1);
    chk("hold_valid", 64'(out_valid), 1);
    out_rdy = 1'b1;
    wait_drain(50);
    chk("hold_drained_occ", 64'(occupancy), 0);

    // trim boundary: FIFO at 48 when the next SOP arrives
    out_rdy = 1'b0;
    stat_clr = 1'b1;
    idle(1);
    stat_clr = 1'b0;
    chk("clr_peak", 64'(peak_occ), 0);
    for (int i = 0; i < 49; i++) begin
      c = (i == 0 ? SOP : '0) | (i == 48 ? EOP : '0);
      send(c, DW'(32'h1000 + i), c, 1'b1);
    end
    chk("pre_trim_occ", 64'(occupancy), 48);
    send(SOP | 32'h5A, DW'(32'h2000), SOP | EOP | TRM | 32'h5A, 1'b1);
    for (int i = 1; i < 5; i++)
      send(i == 4 ? EOP : '0, DW'(32'h2000 + i), '0, 1'b0);
    idle(1);
    chk("trim_occ", 64'(occupancy), 49);
    chk("trim_cnt", 64'(trim_cnt), 1);
    chk("trim_peak", 64'(peak_occ), 49);
    chk("trim_drop_cnt", 64'(drop_cnt), 0);
    out_rdy = 1'b1;
    wait_drain(300);
    chk("trim_drained_occ", 64'(occupancy), 0);

    // fill to 64, overflow one word, then drop a new packet
    out_rdy = 1'b0;
    stat_clr = 1'b1;
    idle(1);
    stat_clr = 1'b0;
    for (int i = 0; i < 66; i++) begin
      c = (i == 0 ? SOP : '0) | (i == 65 ? EOP : '0);
      send(c, DW'(32'h3000 + i), c, i < 65);
    end
    send(SOP | EOP, DW'(32'h4000), '0, 1'b0);
    idle(1);
    chk("full_occ", 64'(occupancy), 64);
    chk("full_peak", 64'(peak_occ), 64);
    chk("full_ovf_cnt", 64'(ovf_cnt), 1);
    chk("full_drop_cnt", 64'(drop_cnt), 1);
    chk("full_trim_cnt", 64'(trim_cnt), 0);
    out_rdy = 1'b1;
    wait_drain(400);
    chk("full_drained_occ", 64'(occupancy), 0);

    stat_clr = 1'b1;
    idle(1);
    stat_clr = 1'b0;
    chk("clr2_peak", 64'(peak_occ), 0);
    chk("clr2_counters", 64'(trim_cnt | drop_cnt | ovf_cnt), 0);

    // reset mid-packet: stray EOP dropped, next packet delivered
    send(SOP, DW'(32'hE1), '0, 1'b0);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    send(EOP, DW'(32'hE2), '0, 1'b0);
    send(SOP | EOP, DW'(32'hE3), SOP | EOP, 1'b1);
    wait_drain(50);
    chk("rstpkt_occ", 64'(occupancy), 0);
    chk("rstpkt_counters", 64'(trim_cnt | drop_cnt | ovf_cnt), 0);

    // paced drain on the DRAIN_INTERVAL=4 instance
    for (int i = 0; i < 8; i++) begin
      c = (i == 0 ? SOP : '0) | (i == 7 ? EOP : '0);
      sb4.push_back({c, DW'(32'h5000 + i)});
      in_wr4 = 1'b1;
      in_ctl4 = c;
      in_data4 = DW'(32'h5000 + i);
      @(posedge clk);
      #1;
    end
    in_wr4 = 1'b0;
    for (int k = 0; k < 100 && sb4.size() != 0; k++) begin
      @(posedge clk);
      #1;
    end
    idle(6);
    chk("pace_words", 64'(n4), 8);
    chk("pace_peak", 64'(peak4), 6);
    chk("pace_occ", 64'(occ4), 0);
    chk("pace_counters", 64'(trim4 | drop4 | ovf4), 0);
    chk("pace_valid_low", 64'(out_valid4), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ndp_egress_queue.md
NDP_EGRESS_QUEUE -- requirements
Module: ndp_egress_queue

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 480, data word width.
REQ-002 SHALL have parameter CTRL_WIDTH, default 32, control word width.
REQ-003 SHALL have parameter ADDR_WIDTH, default 6, FIFO depth 2**ADDR_WIDTH words.
REQ-004 SHALL have parameter TRIM_THRESH, default 48, occupancy at which new packets are trimmed.
REQ-005 SHALL have parameter DRAIN_INTERVAL, default 1, minimum cycles between pops (models the 100G egress rate).
REQ-006 SHALL have ports: clk, input, 1, sole clock; rst, input, 1, synchronous active-high reset.
REQ-007 SHALL have ports: in_wr, input, 1, word valid from the crossbar output; in_ctl, input, CTRL_WIDTH, control (bit CTRL_WIDTH-1 SOP, bit CTRL_WIDTH-2 EOP, bit CTRL_WIDTH-3 trim flag); in_data, input, DATA_WIDTH, payload word.
REQ-008 SHALL have ports: out_valid, output, 1; out_ctl, output, CTRL_WIDTH; out_data, output, DATA_WIDTH; out_rdy, input, 1, downstream accept.
REQ-009 SHALL have ports: occupancy, output, ADDR_WIDTH+1, current FIFO words; peak_occ, output, ADDR_WIDTH+1, high watermark; trim_cnt, drop_cnt, ovf_cnt, output, 32 each; stat_clr, input, 1, clears peak and counters.

Function
REQ-010 SHALL accept one word per cycle when in_wr=1; no backpressure to the crossbar.
REQ-011 SHALL run an ingress FSM with states IDLE, PASS, TRIM, DROP.
REQ-012 IDLE, in_wr with SOP: if occupancy == 2**ADDR_WIDTH -> packet dropped, drop_cnt+1, go DROP (or stay IDLE if EOP also set).
REQ-013 IDLE, SOP, occupancy >= TRIM_THRESH and not full -> enqueue that word only with EOP and trim flag forced to 1, trim_cnt+1, go TRIM (stay IDLE if EOP).
REQ-014 IDLE, SOP, occupancy < TRIM_THRESH -> enqueue unmodified, go PASS (stay IDLE if EOP).
REQ-015 IDLE, in_wr without SOP SHALL be discarded silently.
REQ-016 PASS: each word enqueued unmodified; EOP -> IDLE; if FIFO full the word is discarded, ovf_cnt+1, state still follows EOP.
REQ-017 TRIM, DROP: words discarded; EOP -> IDLE.
REQ-018 SOP seen in PASS/TRIM/DROP SHALL be treated as a new packet per REQ-012..014 (previous packet abandoned).
REQ-019 Full/threshold decisions SHALL use occupancy registered at the start of the cycle.
REQ-020 Pop condition: FIFO non-empty AND pace counter == 0 AND (out_valid == 0 OR out_rdy == 1).
REQ-021 On pop, out_valid/out_ctl/out_data SHALL load the FIFO head at the next edge; pace counter loads DRAIN_INTERVAL-1.
REQ-022 When out_rdy=1 and no pop, out_valid SHALL clear next cycle; out_ctl/out_data hold while out_valid=1 and out_rdy=0.
REQ-023 Pace counter SHALL decrement by 1 per cycle when non-zero.
REQ-024 First-word latency, empty FIFO, pace 0: in_wr at cycle N -> out_valid at cycle N+2.
REQ-025 occupancy SHALL count FIFO entries only (not the output register); simultaneous push and pop leaves it unchanged.
REQ-026 Pointers SHALL wrap modulo 2**ADDR_WIDTH.
REQ-027 peak_occ SHALL update to occupancy whenever occupancy > peak_occ.
REQ-028 Counters SHALL wrap at 2**32.
REQ-029 stat_clr SHALL zero peak_occ and all counters next cycle; a same-cycle increment is lost.

Reset
REQ-030 On rst: out_valid, out_ctl, out_data, occupancy, peak_occ, all counters, pointers, pace counter = 0; FSM = IDLE.
REQ-031 rst mid-packet SHALL abandon the packet; following non-SOP words are discarded per REQ-015.

Verification
REQ-032 Single packet of 3 words (SOP, -, EOP), out_rdy=1, DRAIN_INTERVAL=1 -> 3 identical words out on cycles N+2..N+4, occupancy returns to 0.
REQ-033 Fill 48 words with out_rdy=0, then send 5-word packet -> 1 word enqueued with SOP, EOP, trim flag=1; trim_cnt=1; occupancy=49.
REQ-034 Fill 64 words with out_rdy=0, send SOP -> drop_cnt=1, occupancy stays 64, peak_occ=64.
REQ-035 DRAIN_INTERVAL=4, 8 words queued, out_rdy=1 -> out_valid pulses every 4th cycle, 8 words total.
REQ-036 out_rdy low for 10 cycles while valid -> out_ctl/out_data stable, no pops, no word loss.
REQ-037 rst asserted mid-packet, then EOP word then a new SOP/EOP word -> EOP word discarded, new word delivered, counters 0.
